// File: rtl/spdif_sub_frame_decoder.sv
// S/PDIF receive sub-frame decoder: measures BMC run lengths on an oversampled line,
// finds B/M/W preambles and presents each decoded 28-slot sub-frame on valid/ready.
module spdif_sub_frame_decoder #(
  parameter int CELL_CLKS = 4
) (
  input  logic        clk512,
  input  logic        reset,
  input  logic        spdif,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_is_frame_start,
  output logic        o_is_left,
  output logic [23:0] o_audio,
  output logic        o_validity,
  output logic        o_user,
  output logic        o_control,
  output logic        o_parity_error,
  output logic        is_locked,
  output logic        is_overrun
);

  typedef enum logic [1:0] {HUNT, PRE, DATA} state_t;
  typedef enum logic [1:0] {RUN_S, RUN_M, RUN_L, RUN_E} run_t;
  typedef enum logic [1:0] {PRE_B, PRE_M, PRE_W} pre_t;
  typedef struct packed {
    logic        fs;
    logic        left;
    logic [23:0] audio;
    logic        v;
    logic        u;
    logic        c;
    logic        pe;
  } sf_t;

  localparam logic [8:0] S_MIN   = 9'(CELL_CLKS / 2);
  localparam logic [8:0] M_MIN   = 9'(3 * CELL_CLKS / 2);
  localparam logic [8:0] L_MIN   = 9'(5 * CELL_CLKS / 2);
  localparam logic [8:0] L_END   = 9'(7 * CELL_CLKS / 2);
  localparam logic [7:0] TO_LAST = 8'(4 * CELL_CLKS - 1);

  // line input: two synchroniser flops plus one delay flop for edge detect
  logic [2:0] sync;
  logic       line_edge;
  assign line_edge = sync[1] ^ sync[2];

  always_ff @(posedge clk512) begin
    if (reset) sync <= '0;
    else       sync <= {sync[1:0], spdif};
  end

  logic [7:0] cnt;
  logic [8:0] len;
  logic       timeout;
  logic       run_vld;
  run_t       run;

  assign len     = {1'b0, cnt} + 9'd1;
  assign timeout = !line_edge && (cnt == TO_LAST);
  assign run_vld = line_edge || timeout;

  always_ff @(posedge clk512) begin
    if (reset)               cnt <= '0;
    else if (line_edge)      cnt <= '0;
    else if (cnt != 8'hFF)   cnt <= cnt + 8'd1;
  end

  always_comb begin
    run = RUN_E;
    if      (len >= S_MIN && len < M_MIN) run = RUN_S;
    else if (len >= M_MIN && len < L_MIN) run = RUN_M;
    else if (len >= L_MIN && len < L_END) run = RUN_L;
    if (timeout) run = RUN_E;
  end

  state_t      state, state_n;
  logic [1:0]  pidx, pidx_n;
  pre_t        pre, pre_n;
  logic        half, half_n;
  logic [4:0]  bcnt, bcnt_n;
  logic [27:0] shreg;
  logic        locked, cur_fs, cur_left, done_q;
  logic        bit_done, bit_val, pre_ok, sub_done;
  run_t        pre_last;

  always_comb begin
    case (pre)
      PRE_B:   pre_last = RUN_L;
      PRE_M:   pre_last = RUN_S;
      default: pre_last = RUN_M;
    endcase
  end

  // state register
  always_ff @(posedge clk512) begin
    if (reset) begin
      state    <= HUNT;
      pidx     <= '0;
      pre      <= PRE_B;
      half     <= 1'b0;
      bcnt     <= '0;
      shreg    <= '0;
      locked   <= 1'b0;
      cur_fs   <= 1'b0;
      cur_left <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_n;
      pidx   <= pidx_n;
      pre    <= pre_n;
      half   <= half_n;
      bcnt   <= bcnt_n;
      done_q <= sub_done;
      locked <= pre_ok || (locked && state_n != HUNT);
      if (bit_done) shreg <= {bit_val, shreg[27:1]};
      if (pre_ok) begin
        cur_fs   <= (pre == PRE_B);
        cur_left <= (pre != PRE_W);
      end
    end
  end

  // next-state logic
  always_comb begin
    state_n = state;
    pidx_n  = pidx;
    pre_n   = pre;
    half_n  = half;
    bcnt_n  = bcnt;
    if (run_vld) begin
      case (state)
        HUNT: if (run == RUN_L) begin state_n = PRE; pidx_n = 2'd1; end
        PRE: begin
          case (pidx)
            2'd0: if (run == RUN_L) pidx_n = 2'd1; else state_n = HUNT;
            2'd1: begin
              pidx_n = 2'd2;
              case (run)
                RUN_S:   pre_n = PRE_B;
                RUN_L:   pre_n = PRE_M;
                RUN_M:   pre_n = PRE_W;
                default: state_n = HUNT;
              endcase
            end
            2'd2: if (run == RUN_S) pidx_n = 2'd3; else state_n = HUNT;
            default: begin
              if (run == pre_last) begin
                state_n = DATA;
                half_n  = 1'b0;
                bcnt_n  = '0;
              end else state_n = HUNT;
            end
          endcase
        end
        DATA: begin
          if (bit_done) begin
            half_n = 1'b0;
            bcnt_n = bcnt + 5'd1;
            if (bcnt == 5'd27) begin state_n = PRE; pidx_n = 2'd0; end
          end else if (!half && run == RUN_S) half_n = 1'b1;
          else state_n = HUNT;
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    bit_done = 1'b0;
    bit_val  = 1'b0;
    pre_ok   = 1'b0;
    if (run_vld) begin
      case (state)
        PRE:  pre_ok = (pidx == 2'd3) && (run == pre_last);
        DATA: begin
          if (!half && run == RUN_M) bit_done = 1'b1;
          else if (half && run == RUN_S) begin bit_done = 1'b1; bit_val = 1'b1; end
        end
        default: ;
      endcase
    end
  end
  assign sub_done = bit_done && (state == DATA) && (bcnt == 5'd27);

  sf_t sf, sf_new;
  assign sf_new = {cur_fs, cur_left, shreg[23:0], shreg[24], shreg[25], shreg[26], ^shreg};

  // output register: a completion while the sink is stalled is dropped
  always_ff @(posedge clk512) begin
    if (reset) begin
      o_valid    <= 1'b0;
      sf         <= '0;
      is_overrun <= 1'b0;
    end else begin
      is_overrun <= 1'b0;
      if (done_q) begin
        if (!o_valid || o_ready) begin
          sf      <= sf_new;
          o_valid <= 1'b1;
        end else is_overrun <= 1'b1;
      end else if (o_ready) o_valid <= 1'b0;
    end
  end

  assign o_is_frame_start = sf.fs;
  assign o_is_left        = sf.left;
  assign o_audio          = sf.audio;
  assign o_validity       = sf.v;
  assign o_user           = sf.u;
  assign o_control        = sf.c;
  assign o_parity_error   = sf.pe;
  assign is_locked        = locked;

endmodule

// File: tb/tb_spdif_sub_frame_decoder.sv
// Directed bench for spdif_sub_frame_decoder: drives BMC sub-frames run by run and
// checks the decoded fields, handshake, overrun, lock, jitter and reset behaviour.
module tb_spdif_sub_frame_decoder;

  logic        clk512 = 1'b0;
  logic        reset, spdif, o_ready;
  logic        o_valid, o_is_frame_start, o_is_left, o_validity, o_user, o_control;
  logic        o_parity_error, is_locked, is_overrun;
  logic [23:0] o_audio;

  spdif_sub_frame_decoder #(.CELL_CLKS(4)) dut (
    .clk512(clk512), .reset(reset), .spdif(spdif),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_is_frame_start(o_is_frame_start), .o_is_left(o_is_left), .o_audio(o_audio),
    .o_validity(o_validity), .o_user(o_user), .o_control(o_control),
    .o_parity_error(o_parity_error), .is_locked(is_locked), .is_overrun(is_overrun)
  );

  always #5 clk512 = ~clk512;

  typedef struct packed {
    logic fs; logic left; logic [23:0] audio; logic v; logic u; logic c; logic pe;
  } obs_t;

  obs_t q[$];
  int   ovr_cnt = 0;
  int   n_cmp = 0, n_err = 0;
  int   jit_en = 0, jit_ph = 0;

  always @(negedge clk512) begin
    if (o_valid && o_ready)
      q.push_back({o_is_frame_start, o_is_left, o_audio, o_validity, o_user, o_control, o_parity_error});
    if (is_overrun) ovr_cnt++;
  end

  function automatic obs_t pop();
    if (q.size() > 0) return q.pop_front();
    return '0;
  endfunction

  function automatic logic [27:0] mk(input logic [23:0] a, input logic v, input logic u,
                                     input logic c, input logic flip);
    logic p;
    p = (^{c, u, v, a}) ^ flip;
    return {p, c, u, v, a};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk512);
    #1;
  endtask

  // one line run of the given number of cells, optionally jittered by +/-1 clk512
  task automatic seg(input int cells);
    int n;
    n = cells * 4;
    if (jit_en != 0) begin n = n + ((jit_ph != 0) ? 1 : -1); jit_ph = (jit_ph == 0); end
    spdif = ~spdif;
    cyc(n);
  endtask

  task automatic send_sf(input int pre, input logic [27:0] slots, input int nslots);
    case (pre)
      0:       begin seg(3); seg(1); seg(1); seg(3); end
      1:       begin seg(3); seg(3); seg(1); seg(1); end
      default: begin seg(3); seg(2); seg(1); seg(2); end
    endcase
    for (int i = 0; i < nslots; i++) begin
      if (slots[i]) begin seg(1); seg(1); end
      else seg(2);
    end
  endtask

  // closing transition that ends the final slot, then the line goes quiet
  task automatic end_line();
    spdif = ~spdif;
    cyc(8);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (is_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", is_locked); end
    n_cmp++; if (o_audio !== 24'h0) begin n_err++; $display("FAIL reset_audio: got %h want 0", o_audio); end
    n_cmp++; if ({o_is_frame_start, o_is_left, o_validity, o_user, o_control, o_parity_error, is_overrun} !== 7'b0)
      begin n_err++; $display("FAIL reset_flags: got %b want 0000000",
        {o_is_frame_start, o_is_left, o_validity, o_user, o_control, o_parity_error, is_overrun}); end
    reset = 1'b0;
    cyc(20);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_single();
    obs_t r;
    q.delete();
    send_sf(0, mk(24'hA5A5A5, 1'b0, 1'b1, 1'b0, 1'b0), 28);
    n_cmp++; if (is_locked !== 1'b1) begin n_err++; $display("FAIL single_locked: got %b want 1", is_locked); end
    spdif = ~spdif;
    cyc(3);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got %b want 0", o_valid); end
    cyc(1);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL latency_rise: got %b want 1", o_valid); end
    cyc(2);
    n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", q.size()); end
    r = pop();
    n_cmp++; if (r.audio !== 24'hA5A5A5) begin n_err++; $display("FAIL single_audio: got %h want a5a5a5", r.audio); end
    n_cmp++; if ({r.fs, r.left, r.v, r.u, r.c, r.pe} !== 6'b110100)
      begin n_err++; $display("FAIL single_flags: got %b want 110100", {r.fs, r.left, r.v, r.u, r.c, r.pe}); end
    cyc(30);
    n_cmp++; if (is_locked !== 1'b0) begin n_err++; $display("FAIL single_unlock: got %b want 0", is_locked); end
  endtask

  task automatic test_stereo();
    obs_t r;
    int   ovr0;
    q.delete();
    ovr0 = ovr_cnt;
    send_sf(0, mk(24'h000001, 1'b0, 1'b0, 1'b0, 1'b0), 28);
    send_sf(2, mk(24'h800000, 1'b0, 1'b0, 1'b0, 1'b0), 28);
    end_line();
    n_cmp++; if (q.size() !== 2) begin n_err++; $display("FAIL stereo_count: got %0d want 2", q.size()); end
    r = pop();
    n_cmp++; if ({r.fs, r.left, r.audio, r.pe} !== {2'b11, 24'h000001, 1'b0})
      begin n_err++; $display("FAIL stereo_left: got fs=%b l=%b a=%h pe=%b want 1 1 000001 0", r.fs, r.left, r.audio, r.pe); end
    r = pop();
    n_cmp++; if ({r.fs, r.left, r.audio, r.pe} !== {2'b00, 24'h800000, 1'b0})
      begin n_err++; $display("FAIL stereo_right: got fs=%b l=%b a=%h pe=%b want 0 0 800000 0", r.fs, r.left, r.audio, r.pe); end
    n_cmp++; if (ovr_cnt !== ovr0) begin n_err++; $display("FAIL stereo_overrun: got %0d want %0d", ovr_cnt, ovr0); end
    cyc(30);
  endtask

  task automatic test_parity();
    obs_t r;
    q.delete();
    send_sf(0, mk(24'h123456, 1'b1, 1'b0, 1'b1, 1'b1), 28);
    end_line();
    n_cmp++; if (is_locked !== 1'b1) begin n_err++; $display("FAIL parity_locked: got %b want 1", is_locked); end
    n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL parity_count: got %0d want 1", q.size()); end
    r = pop();
    n_cmp++; if (r.pe !== 1'b1) begin n_err++; $display("FAIL parity_err: got %b want 1", r.pe); end
    n_cmp++; if ({r.audio, r.v, r.u, r.c} !== {24'h123456, 3'b101})
      begin n_err++; $display("FAIL parity_data: got %h %b%b%b want 123456 101", r.audio, r.v, r.u, r.c); end
    cyc(30);
  endtask

  task automatic test_overrun();
    obs_t r;
    int   ovr0;
    q.delete();
    ovr0 = ovr_cnt;
    o_ready = 1'b0;
    send_sf(0, mk(24'h111111, 1'b0, 1'b0, 1'b0, 1'b0), 28);
    send_sf(2, mk(24'h222222, 1'b1, 1'b1, 1'b1, 1'b0), 28);
    end_line();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid_held: got %b want 1", o_valid); end
    n_cmp++; if ({o_audio, o_is_left, o_user} !== {24'h111111, 2'b10})
      begin n_err++; $display("FAIL ovr_fields_held: got %h l=%b u=%b want 111111 1 0", o_audio, o_is_left, o_user); end
    n_cmp++; if (ovr_cnt - ovr0 !== 1) begin n_err++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - ovr0); end
    o_ready = 1'b1;
    cyc(4);
    n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", q.size()); end
    r = pop();
    n_cmp++; if (r.audio !== 24'h111111) begin n_err++; $display("FAIL ovr_first: got %h want 111111", r.audio); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got %b want 0", o_valid); end
    cyc(30);
  endtask

  task automatic test_timeout();
    obs_t r;
    q.delete();
    send_sf(0, mk(24'hABCDEF, 1'b0, 1'b0, 1'b0, 1'b0), 10);
    cyc(4);
    n_cmp++; if (is_locked !== 1'b1) begin n_err++; $display("FAIL to_locked_before: got %b want 1", is_locked); end
    cyc(12);
    n_cmp++; if (is_locked !== 1'b0) begin n_err++; $display("FAIL to_unlocked: got %b want 0", is_locked); end
    cyc(20);
    n_cmp++; if (q.size() !== 0 || o_valid !== 1'b0)
      begin n_err++; $display("FAIL to_no_output: got count=%0d valid=%b want 0 0", q.size(), o_valid); end
    send_sf(1, mk(24'h654321, 1'b0, 1'b1, 1'b1, 1'b0), 28);
    end_line();
    n_cmp++; if (is_locked !== 1'b1) begin n_err++; $display("FAIL to_relock: got %b want 1", is_locked); end
    r = pop();
    n_cmp++; if ({r.fs, r.left, r.audio, r.u, r.c, r.pe} !== {2'b01, 24'h654321, 3'b110})
      begin n_err++; $display("FAIL to_relock_data: got fs=%b l=%b a=%h u=%b c=%b pe=%b want 0 1 654321 1 1 0",
        r.fs, r.left, r.audio, r.u, r.c, r.pe); end
    cyc(30);
  endtask

  task automatic test_jitter();
    obs_t r;
    q.delete();
    jit_en = 1;
    send_sf(0, mk(24'h3C5A96, 1'b1, 1'b0, 1'b1, 1'b0), 28);
    send_sf(2, mk(24'h0F0F0F, 1'b0, 1'b1, 1'b0, 1'b0), 28);
    jit_en = 0;
    end_line();
    n_cmp++; if (q.size() !== 2) begin n_err++; $display("FAIL jit_count: got %0d want 2", q.size()); end
    r = pop();
    n_cmp++; if (r !== {2'b11, 24'h3C5A96, 4'b1010})
      begin n_err++; $display("FAIL jit_first: got %h want %h", r, {2'b11, 24'h3C5A96, 4'b1010}); end
    r = pop();
    n_cmp++; if (r !== {2'b00, 24'h0F0F0F, 4'b0100})
      begin n_err++; $display("FAIL jit_second: got %h want %h", r, {2'b00, 24'h0F0F0F, 4'b0100}); end
    cyc(30);
  endtask

  task automatic test_reset_mid();
    obs_t r;
    q.delete();
    o_ready = 1'b0;
    send_sf(0, mk(24'h777777, 1'b0, 1'b0, 1'b0, 1'b0), 28);
    send_sf(2, mk(24'h999999, 1'b0, 1'b0, 1'b0, 1'b0), 12);
    n_cmp++; if ({o_valid, is_locked} !== 2'b11)
      begin n_err++; $display("FAIL rmid_pre: got valid=%b locked=%b want 1 1", o_valid, is_locked); end
    reset = 1'b1;
    cyc(1);
    n_cmp++; if ({o_valid, is_locked, is_overrun, o_is_left, o_is_frame_start} !== 5'b0)
      begin n_err++; $display("FAIL rmid_flags: got %b want 00000", {o_valid, is_locked, is_overrun, o_is_left, o_is_frame_start}); end
    n_cmp++; if (o_audio !== 24'h0) begin n_err++; $display("FAIL rmid_audio: got %h want 0", o_audio); end
    reset = 1'b0;
    o_ready = 1'b1;
    cyc(30);
    q.delete();
    send_sf(0, mk(24'h5A5A5A, 1'b0, 1'b0, 1'b1, 1'b0), 28);
    end_line();
    n_cmp++; if (q.size() !== 1) begin n_err++; $display("FAIL rmid_count: got %0d want 1", q.size()); end
    r = pop();
    n_cmp++; if (r !== {2'b11, 24'h5A5A5A, 4'b0010})
      begin n_err++; $display("FAIL rmid_data: got %h want %h", r, {2'b11, 24'h5A5A5A, 4'b0010}); end
    cyc(30);
  endtask

  initial begin
    reset   = 1'b1;
    spdif   = 1'b0;
    o_ready = 1'b1;
    @(posedge clk512);
    #1;
    test_reset();
    test_single();
    test_stereo();
    test_parity();
    test_overrun();
    test_timeout();
    test_jitter();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
